hht_gather_engine: RTL and testbench

- Parametrised sparse-vector gather engine for the HHT datapath.
- Streams column indices from memory port 1 starting at col_base, then fetches vector values from memory port 2 at v_base + index.
- Buffers gathered values in an internal show-ahead FIFO and delivers them through a ready/valid port.
- Adds over the previous generation: configurable widths and FIFO depth, back-pressure, an out-of-range index check and a last-element tag.

---
 rtl/hht_gather_engine.sv | 261 ++++++++++++++++++++++++++
 tb/tb_hht_gather_engine.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hht_gather_engine.sv
// ---------------------------------------------------------------------------
// hht_gather_engine
//
// Sparse-vector gather engine. A job reads csize column indices from the
// index memory (port 1) starting at col_base, looks up each index in the
// vector memory (port 2) at v_base + index, and streams the gathered values
// out through a show-ahead FIFO with a ready/valid handshake. Indices at or
// beyond vlen produce a zero value and raise the sticky oob flag. The final
// element of a job carries out_last.
//
// Ports:
//   Clk, Rst            clock (rising edge), asynchronous active-high reset
//   start               one-cycle pulse, accepted only while idle
//   col_base, v_base    base addresses of the index and value arrays
//   csize, vlen         number of indices to gather, vector length
//   addr1 / dataIn1     index-memory address / combinational read data
//   addr2 / dataIn2     vector-memory address / combinational read data
//   out_valid/out_data  FIFO head valid / head value
//   out_last            head is the final element of the job
//   out_ready           consumer accepts head when out_valid & out_ready
//   busy                job in progress (RUN or DRAIN)
//   done                one-cycle pulse when the last element is pushed
//   oob                 sticky: some index >= vlen in the current job
// ---------------------------------------------------------------------------
module hht_gather_engine #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 8
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] col_base,
  input  logic [ADDR_W-1:0] v_base,
  input  logic [ADDR_W-1:0] csize,
  input  logic [ADDR_W-1:0] vlen,
  output logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] dataIn1,
  output logic [ADDR_W-1:0] addr2,
  input  logic [DATA_W-1:0] dataIn2,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic              oob
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int CMP_W = (DATA_W > ADDR_W) ? DATA_W : ADDR_W;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN
  } state_t;

  state_t r_state;
  state_t w_nextState;

  // Latched job configuration
  logic [ADDR_W-1:0] r_vBase;
  logic [ADDR_W-1:0] r_csize;
  logic [ADDR_W-1:0] r_vlen;

  // Stage 1 (index fetch) state
  logic [ADDR_W-1:0] r_issueCnt;
  logic [ADDR_W-1:0] r_addr1;

  // Stage 2 (value fetch) state
  logic              r_s2Valid;
  logic [DATA_W-1:0] r_idx;
  logic              r_idxLast;
  logic [ADDR_W-1:0] r_addr2;

  // Status flags
  logic r_done;
  logic r_oob;

  // Output FIFO storage: {last, value} per entry
  logic [DATA_W:0]  r_mem [DEPTH];
  logic [PTR_W-1:0] r_wrPtr;
  logic [PTR_W-1:0] r_rdPtr;
  logic [CNT_W-1:0] r_count;

  logic              w_startAccept;
  logic              w_busy;
  logic [CNT_W-1:0]  w_occupancy;
  logic              w_issue;
  logic [ADDR_W-1:0] w_issueNext;
  logic              w_push;
  logic              w_pop;
  logic              w_idxInRange;
  logic [DATA_W-1:0] w_pushData;
  logic              w_lastPushed;
  logic              w_fifoEmptying;
  logic [DATA_W:0]   w_head;

  // Occupancy counts the element already in stage 2, because stage 2 cannot
  // stall: anything issued now is guaranteed a FIFO slot two edges later.
  assign w_occupancy = r_count + CNT_W'(r_s2Valid);
  assign w_issue     = (r_state == ST_RUN) && (r_issueCnt < r_csize) &&
                       (w_occupancy < CNT_W'(DEPTH));
  assign w_issueNext = r_issueCnt + ADDR_W'(1);

  // Range check is done at the wider of the two widths so neither the index
  // nor the vector length is truncated.
  assign w_idxInRange = CMP_W'(r_idx) < CMP_W'(r_vlen);
  assign w_pushData   = w_idxInRange ? dataIn2 : '0;
  assign w_push       = r_s2Valid;
  assign w_lastPushed = r_s2Valid && r_idxLast;

  assign out_valid = (r_count != '0);
  assign w_pop     = out_valid && out_ready;
  assign w_head    = r_mem[r_rdPtr];

  // DRAIN ends on the same edge that removes the final FIFO entry.
  assign w_fifoEmptying = (r_count == '0) ||
                          ((r_count == CNT_W'(1)) && w_pop && !w_push);

  // State register
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic and state-derived controls. A start with csize==0 is
  // accepted (it pulses done) but never leaves IDLE.
  always_comb begin
    w_nextState   = r_state;
    w_busy        = 1'b0;
    w_startAccept = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        w_startAccept = start;
        if (start && (csize != '0)) begin
          w_nextState = ST_RUN;
        end
      end
      ST_RUN: begin
        w_busy = 1'b1;
        if (w_lastPushed) begin
          w_nextState = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        w_busy = 1'b1;
        if (w_fifoEmptying) begin
          w_nextState = ST_IDLE;
        end
      end
      default: begin
        w_nextState = ST_IDLE;
      end
    endcase
  end

  // Configuration latch and stage 1. addr1 is kept registered so it holds
  // its value when stalled or idle; it only advances while another index
  // remains, so after the final issue it keeps pointing at the last index.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_vBase    <= '0;
      r_csize    <= '0;
      r_vlen     <= '0;
      r_issueCnt <= '0;
      r_addr1    <= '0;
    end else if (w_startAccept) begin
      r_vBase    <= v_base;
      r_csize    <= csize;
      r_vlen     <= vlen;
      r_issueCnt <= '0;
      if (csize != '0) begin
        r_addr1 <= col_base;
      end
    end else if (w_issue) begin
      r_issueCnt <= w_issueNext;
      if (w_issueNext < r_csize) begin
        r_addr1 <= r_addr1 + ADDR_W'(1);
      end
    end
  end

  // Stage 2 capture. addr2 is computed from the freshly read index so it is
  // already valid in the cycle the value is looked up.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_s2Valid <= 1'b0;
      r_idx     <= '0;
      r_idxLast <= 1'b0;
      r_addr2   <= '0;
    end else begin
      r_s2Valid <= w_issue;
      if (w_issue) begin
        r_idx     <= dataIn1;
        r_idxLast <= (r_issueCnt == (r_csize - ADDR_W'(1)));
        r_addr2   <= r_vBase + ADDR_W'(dataIn1);
      end
    end
  end

  // done pulses one cycle after either the last push or a zero-length
  // start; oob is sticky for the whole job and cleared by the next start.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_done <= 1'b0;
      r_oob  <= 1'b0;
    end else begin
      r_done <= (w_startAccept && (csize == '0)) || w_lastPushed;
      if (w_startAccept) begin
        r_oob <= 1'b0;
      end else if (w_push && !w_idxInRange) begin
        r_oob <= 1'b1;
      end
    end
  end

  // FIFO storage write; contents need no reset because the head is masked
  // whenever the FIFO is empty.
  always_ff @(posedge Clk) begin
    if (w_push) begin
      r_mem[r_wrPtr] <= {r_idxLast, w_pushData};
    end
  end

  // FIFO pointers and count. DEPTH is a power of two so the pointers wrap
  // naturally. A simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign addr1    = r_addr1;
  assign addr2    = r_addr2;
  assign out_data = out_valid ? w_head[DATA_W-1:0] : '0;
  assign out_last = out_valid && w_head[DATA_W];
  assign busy     = w_busy;
  assign done     = r_done;
  assign oob      = r_oob;

endmodule

// File: tb/tb_hht_gather_engine.sv
// ---------------------------------------------------------------------------
// tb_hht_gather_engine
//
// Drives two engines from the same job stimulus: dutA with an 8-entry FIFO
// and dutB with a 2-entry FIFO. Each has its own view of shared index and
// vector memories. Expected {last, value} pairs are queued when a job is
// started and compared as each engine hands out elements.
// ---------------------------------------------------------------------------
module tb_hht_gather_engine;

  typedef struct {
    logic [31:0]       colBase;
    logic [31:0]       vBase;
    logic [31:0]       csize;
    logic [31:0]       vlen;
    logic [3:0][31:0]  colVals;
    logic [3:0][31:0]  expData;
    logic              expOob;
  } jobVec_t;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        start;
  logic [31:0] colBase;
  logic [31:0] vBase;
  logic [31:0] csize;
  logic [31:0] vlen;
  logic        outReady;

  logic [31:0] addr1A, dataIn1A, addr2A, dataIn2A, outDataA;
  logic        outValidA, outLastA, busyA, doneA, oobA;
  logic [31:0] addr1B, dataIn1B, addr2B, dataIn2B, outDataB;
  logic        outValidB, outLastB, busyB, doneB, oobB;

  logic [31:0] colMem [1024];
  logic [31:0] vecMem [1024];

  jobVec_t     vecTable [5];
  logic [32:0] qA [$];
  logic [32:0] qB [$];
  int          timesA [$];

  int checks = 0;
  int errors = 0;
  int cycle = 0;
  int startCycle = 0;
  int doneCntA = 0, doneCntB = 0, lastCntA = 0, lastCntB = 0;
  int acceptA = 0, acceptB = 0;
  int baseDoneA, baseDoneB, baseLastA, baseLastB, baseAcceptA, baseAcceptB;
  logic        expLongOob;
  logic [32:0] expA, expB;

  assign dataIn1A = colMem[addr1A[9:0]];
  assign dataIn2A = vecMem[addr2A[9:0]];
  assign dataIn1B = colMem[addr1B[9:0]];
  assign dataIn2B = vecMem[addr2B[9:0]];

  hht_gather_engine #(.DATA_W(32), .ADDR_W(32), .DEPTH(8)) dutA (
    .Clk(Clk), .Rst(Rst), .start(start),
    .col_base(colBase), .v_base(vBase), .csize(csize), .vlen(vlen),
    .addr1(addr1A), .dataIn1(dataIn1A), .addr2(addr2A), .dataIn2(dataIn2A),
    .out_valid(outValidA), .out_data(outDataA), .out_last(outLastA),
    .out_ready(outReady), .busy(busyA), .done(doneA), .oob(oobA)
  );

  hht_gather_engine #(.DATA_W(32), .ADDR_W(32), .DEPTH(2)) dutB (
    .Clk(Clk), .Rst(Rst), .start(start),
    .col_base(colBase), .v_base(vBase), .csize(csize), .vlen(vlen),
    .addr1(addr1B), .dataIn1(dataIn1B), .addr2(addr2B), .dataIn2(dataIn2B),
    .out_valid(outValidB), .out_data(outDataB), .out_last(outLastB),
    .out_ready(outReady), .busy(busyB), .done(doneB), .oob(oobB)
  );

  always #5 Clk = ~Clk;

  // Cycle counter, advanced on every active edge
  always @(posedge Clk) cycle <= cycle + 1;

  // Single comparison with failure report
  task automatic checkVal(input string name, input logic [63:0] actual,
                          input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Scoreboard for dutA: an accepted element is compared against the queue
  always @(negedge Clk) begin
    if (!Rst && outValidA && outReady) begin
      acceptA++;
      timesA.push_back(cycle);
      if (outLastA) lastCntA++;
      if (qA.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL A unexpected output: got %0d expected none", outDataA);
      end else begin
        expA = qA.pop_front();
        checkVal("A out_data", {32'd0, outDataA}, {32'd0, expA[31:0]});
        checkVal("A out_last", {63'd0, outLastA}, {63'd0, expA[32]});
      end
    end
    if (doneA) doneCntA++;
  end

  // Scoreboard for dutB
  always @(negedge Clk) begin
    if (!Rst && outValidB && outReady) begin
      acceptB++;
      if (outLastB) lastCntB++;
      if (qB.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL B unexpected output: got %0d expected none", outDataB);
      end else begin
        expB = qB.pop_front();
        checkVal("B out_data", {32'd0, outDataB}, {32'd0, expB[31:0]});
        checkVal("B out_last", {63'd0, outLastB}, {63'd0, expB[32]});
      end
    end
    if (doneB) doneCntB++;
  end

  task automatic setVec(input int n, input logic [31:0] cb, vb, cs, vl,
                        input logic [31:0] c0, c1, c2, c3,
                        input logic [31:0] e0, e1, e2, e3, input logic eo);
    vecTable[n].colBase = cb;
    vecTable[n].vBase   = vb;
    vecTable[n].csize   = cs;
    vecTable[n].vlen    = vl;
    vecTable[n].colVals = {c3, c2, c1, c0};
    vecTable[n].expData = {e3, e2, e1, e0};
    vecTable[n].expOob  = eo;
  endtask

  task automatic snapshot();
    baseDoneA = doneCntA;  baseDoneB = doneCntB;
    baseLastA = lastCntA;  baseLastB = lastCntB;
    baseAcceptA = acceptA; baseAcceptB = acceptB;
  endtask

  // Pulse start for one active edge; startCycle marks that edge
  task automatic startJob(input logic [31:0] cb, vb, cs, vl);
    @(negedge Clk);
    colBase = cb;
    vBase   = vb;
    csize   = cs;
    vlen    = vl;
    start   = 1'b1;
    @(posedge Clk);
    #1;
    start = 1'b0;
    startCycle = cycle;
  endtask

  // Load a table job into memory, queue its expected results, start it
  task automatic applyStimulus(input int n);
    logic [31:0] a;
    int cs;
    cs = int'(vecTable[n].csize);
    for (int k = 0; k < cs; k++) begin
      a = vecTable[n].colBase + 32'(k);
      colMem[a[9:0]] = vecTable[n].colVals[k];
    end
    snapshot();
    for (int k = 0; k < cs; k++) begin
      qA.push_back({k == cs - 1, vecTable[n].expData[k]});
      qB.push_back({k == cs - 1, vecTable[n].expData[k]});
    end
    startJob(vecTable[n].colBase, vecTable[n].vBase,
             vecTable[n].csize, vecTable[n].vlen);
  endtask

  // Long job: expectations from a reference model of the gather
  task automatic applyLong(input logic [31:0] cb, vb, cs, vl);
    logic [31:0] a, idx, val;
    expLongOob = 1'b0;
    snapshot();
    for (int k = 0; k < int'(cs); k++) begin
      a   = cb + 32'(k);
      idx = colMem[a[9:0]];
      if (idx < vl) begin
        a   = vb + idx;
        val = vecMem[a[9:0]];
      end else begin
        val = 32'd0;
        expLongOob = 1'b1;
      end
      qA.push_back({k == int'(cs) - 1, val});
      qB.push_back({k == int'(cs) - 1, val});
    end
    startJob(cb, vb, cs, vl);
  endtask

  // Wait until both engines are idle and have delivered everything
  task automatic waitIdle(input bit randomReady, input int limit);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < limit; k++) begin
      @(posedge Clk);
      #1;
      if (randomReady) outReady = 1'($urandom_range(0, 1));
      @(negedge Clk);
      if (!busyA && !busyB && qA.size() == 0 && qB.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL idle timeout: got busyA=%0d busyB=%0d pendA=%0d pendB=%0d expected all 0",
               busyA, busyB, qA.size(), qB.size());
    end
    outReady = 1'b1;
  endtask

  task automatic checkOutput(input string tag, input logic expOob, input int expCount);
    checkVal({tag, " oob A"}, {63'd0, oobA}, {63'd0, expOob});
    checkVal({tag, " oob B"}, {63'd0, oobB}, {63'd0, expOob});
    checkVal({tag, " done A"}, 64'(doneCntA - baseDoneA), 64'd1);
    checkVal({tag, " done B"}, 64'(doneCntB - baseDoneB), 64'd1);
    checkVal({tag, " last A"}, 64'(lastCntA - baseLastA), 64'd1);
    checkVal({tag, " last B"}, 64'(lastCntB - baseLastB), 64'd1);
    checkVal({tag, " count A"}, 64'(acceptA - baseAcceptA), 64'(expCount));
    checkVal({tag, " count B"}, 64'(acceptB - baseAcceptB), 64'(expCount));
  endtask

  // Global watchdog
  initial begin
    #600000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int baseTimes;
    bit reached;

    Rst = 1'b1;
    start = 1'b0;
    colBase = '0; vBase = '0; csize = '0; vlen = '0;
    outReady = 1'b0;
    for (int i = 0; i < 1024; i++) begin
      colMem[i] = 32'd0;
      vecMem[i] = 32'd1000 + 32'(i);
    end
    vecMem[1] = 32'd55;
    vecMem[2] = 7;   vecMem[3] = 93;  vecMem[4] = 68;  vecMem[5] = 80;
    vecMem[6] = 90;  vecMem[7] = 15;  vecMem[8] = 4;   vecMem[9] = 8;
    vecMem[10] = 35; vecMem[11] = 81; vecMem[12] = 45; vecMem[13] = 52;
    vecMem[14] = 48; vecMem[15] = 69; vecMem[16] = 100; vecMem[17] = 34;
    for (int k = 0; k < 230; k++) colMem[300 + k] = 32'($urandom_range(0, 19));

    //        n  colBase        vBase          cs vlen  col indices       expected data    oob
    setVec(0, 32'd180,       32'd2,         4, 16,  15, 2, 11, 7,     34, 68, 52, 8,   1'b0);
    setVec(1, 32'd200,       32'd2,         3, 16,  15, 16, 3, 0,     34, 0, 80, 0,    1'b1);
    setVec(2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2, 16,  4, 3, 0, 0,       7, 55, 0, 0,     1'b0);
    setVec(3, 32'd210,       32'd2,         2, 5,   4, 5, 0, 0,       90, 0, 0, 0,     1'b1);
    setVec(4, 32'd220,       32'd2,         1, 16,  0, 0, 0, 0,       7, 0, 0, 0,      1'b0);
    colMem[1023] = 32'd4;
    colMem[0]    = 32'd3;

    // Reset state
    repeat (2) @(negedge Clk);
    checkVal("reset flags A", {59'd0, outValidA, outLastA, busyA, doneA, oobA}, 64'd0);
    checkVal("reset out_data A", {32'd0, outDataA}, 64'd0);
    checkVal("reset addr A", {addr1A, addr2A}, 64'd0);
    checkVal("reset flags B", {59'd0, outValidB, outLastB, busyB, doneB, oobB}, 64'd0);
    Rst = 1'b0;
    outReady = 1'b1;
    repeat (2) @(negedge Clk);

    // Directed jobs from the table
    for (int n = 0; n < 5; n++) begin
      $display("[TB] table job %0d", n);
      baseTimes = timesA.size();
      applyStimulus(n);
      waitIdle(1'b0, 200);
      checkOutput($sformatf("job%0d", n), vecTable[n].expOob, int'(vecTable[n].csize));
      if (n == 0) begin
        if (timesA.size() >= baseTimes + 4) begin
          checkVal("latency A", 64'(timesA[baseTimes] - startCycle), 64'd2);
          checkVal("throughput A", 64'(timesA[baseTimes + 3] - timesA[baseTimes]), 64'd3);
        end else begin
          checks++;
          errors++;
          $display("[TB] FAIL timing A: got %0d outputs expected 4", timesA.size() - baseTimes);
        end
      end
    end

    // Zero-length job: done pulse only
    $display("[TB] zero-length job");
    snapshot();
    startJob(32'd180, 32'd2, 32'd0, 32'd16);
    @(negedge Clk);
    checkVal("zero done A", {63'd0, doneA}, 64'd1);
    checkVal("zero done B", {63'd0, doneB}, 64'd1);
    checkVal("zero busy", {62'd0, busyA, busyB}, 64'd0);
    @(negedge Clk);
    checkVal("zero done cleared", {62'd0, doneA, doneB}, 64'd0);
    repeat (3) @(negedge Clk);
    checkVal("zero no output", {62'd0, outValidA, outValidB}, 64'd0);
    checkVal("zero done count A", 64'(doneCntA - baseDoneA), 64'd1);

    // Start while busy is ignored
    $display("[TB] start while busy");
    applyStimulus(0);
    startJob(32'd200, 32'd2, 32'd3, 32'd16);
    waitIdle(1'b0, 200);
    checkOutput("busy-start", 1'b0, 4);

    // Back-pressure: consumer stalls for 10 cycles
    $display("[TB] back-pressure");
    outReady = 1'b0;
    applyStimulus(0);
    repeat (10) @(negedge Clk);
    checkVal("stall addr1 B", {32'd0, addr1B}, 64'd182);
    checkVal("stall addr1 A", {32'd0, addr1A}, 64'd183);
    checkVal("stall head B", {31'd0, outValidB, outDataB}, {31'd0, 1'b1, 32'd34});
    @(posedge Clk);
    #1;
    outReady = 1'b1;
    waitIdle(1'b0, 200);
    checkOutput("backpressure", 1'b0, 4);

    // Reset in the middle of a long job
    $display("[TB] reset mid-job");
    applyLong(32'd300, 32'd2, 32'd230, 32'd16);
    reached = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(posedge Clk);
      #1;
      outReady = 1'($urandom_range(0, 1));
      @(negedge Clk);
      if (acceptA - baseAcceptA >= 2) begin
        reached = 1'b1;
        break;
      end
    end
    checks++;
    if (!reached) begin
      errors++;
      $display("[TB] FAIL mid-job outputs: got %0d expected 2", acceptA - baseAcceptA);
    end
    #2;
    Rst = 1'b1;
    #1;
    checkVal("midreset flags A", {59'd0, outValidA, outLastA, busyA, doneA, oobA}, 64'd0);
    checkVal("midreset addr A", {addr1A, addr2A}, 64'd0);
    checkVal("midreset out_data A", {32'd0, outDataA}, 64'd0);
    checkVal("midreset flags B", {59'd0, outValidB, outLastB, busyB, doneB, oobB}, 64'd0);
    checkVal("midreset addr B", {addr1B, addr2B}, 64'd0);
    qA.delete();
    qB.delete();
    repeat (2) @(negedge Clk);
    Rst = 1'b0;
    outReady = 1'b1;
    applyStimulus(0);
    waitIdle(1'b0, 200);
    checkOutput("post-reset", 1'b0, 4);

    // Long job with random back-pressure
    $display("[TB] long job");
    applyLong(32'd300, 32'd2, 32'd230, 32'd16);
    waitIdle(1'b1, 5000);
    checkOutput("long", expLongOob, 230);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
